hilo_seq: RTL and testbench
===========================

Name: hilo_seq

Overview:
- Sequencer and architectural HI/LO register pair that sits directly downstream of the Booth multiplier.
- Accepts a multiply request from the control unit and latches the operands.
- Pulses the multiplier's init, waits a fixed latency, then captures the multiplier's hi/lo outputs into HI/LO.
- Also services mthi/mtlo writes, and gives the control unit busy/done so it can stall mfhi/mflo.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_LAT, 34: cycles from the first cycle with mult_init high until mult_hi/mult_lo are valid. Legal range 2..63.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  multiply request; sampled only in IDLE.
- op_a  input  WIDTH  multiplicand.
- op_b  input  WIDTH  multiplier.
- cancel  input  1  abort an in-flight multiply.
- mthi  input  1  write wdata into HI.
- mtlo  input  1  write wdata into LO.
- wdata  input  WIDTH  data for mthi/mtlo.
- mult_hi  input  WIDTH  multiplier high result.
- mult_lo  input  WIDTH  multiplier low result.
- mult_a  output  WIDTH  registered operand to the multiplier.
- mult_b  output  WIDTH  registered operand to the multiplier.
- mult_init  output  1  one-cycle start pulse to the multiplier.
- mult_stop  output  1  one-cycle abort pulse to the multiplier.
- hi_q  output  WIDTH  architectural HI.
- lo_q  output  WIDTH  architectural LO.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse during the CAPTURE state.

Behaviour:
- Reset (rst=0, async): state=IDLE and counter=0. Outputs are all zero: hi_q, lo_q, mult_a, mult_b, mult_init, mult_stop, busy, done.
- All outputs are registered except busy, which decodes state.
- States and transitions:
  - IDLE: if start=1 at edge E0, latch mult_a<=op_a and mult_b<=op_b, then go to LAUNCH.
  - LAUNCH: mult_init=1 for exactly this cycle. At the next edge (E1) load counter=MULT_LAT-1 and go to WAIT.
  - WAIT: on each edge, if counter==0 go to CAPTURE, else decrement. WAIT therefore lasts exactly MULT_LAT cycles.
  - CAPTURE: done=1. At the next edge, hi_q<=mult_hi, lo_q<=mult_lo, and state returns to IDLE.
- Latency: done is high in the cycle after edge E(MULT_LAT+1). New hi_q/lo_q are visible after edge E(MULT_LAT+2).
- Counter is 6 bits and never wraps: it is loaded only in LAUNCH and decremented only while nonzero.
- start while busy: ignored; operands are not re-latched.
- mthi/mtlo in IDLE: the register is written at the edge.
- mthi/mtlo while busy: dropped; the control unit must stall on busy.
- mthi and mtlo in the same cycle: both registers take wdata.
- start together with mthi/mtlo in IDLE: both act. The write lands now; the multiply result overwrites HI/LO at capture.
- cancel in LAUNCH or WAIT: mult_stop=1 for one cycle (the cycle after cancel is sampled). State goes to IDLE, hi_q/lo_q are unchanged, no done pulse.
- cancel in IDLE: no effect.
- cancel in CAPTURE: ignored; the capture completes.
- cancel and start together in IDLE: start wins, cancel is ignored.
- Reset mid-operation: immediate return to IDLE with zeroed outputs; no mult_stop pulse is generated.
- Arithmetic: none performed here. mult_hi and mult_lo are captured verbatim as WIDTH bits each.

Optional Feature:
- Macro HILO_FWD_EN.
- Defined: during CAPTURE, hi_q/lo_q present mult_hi/mult_lo combinationally, a one-cycle-early forward for a stalled mfhi/mflo. Registered values update at the same edge as in the base behaviour.
- Not defined: hi_q/lo_q are purely registered.

Test Plan:
- Multiply 6 x 7, MULT_LAT=34, behavioural multiplier model: start at E0 -> mult_init high only in cycle 1; done high in cycle 36; hi_q=0x00000000 and lo_q=0x0000002A after E36.
- Multiply -3 x 5 (0xFFFFFFFD x 0x00000005) -> hi_q=0xFFFFFFFF, lo_q=0xFFFFFFF1; busy high exactly from cycle 1 through cycle 36.
- mthi with wdata=0x12345678 in IDLE, then mtlo with wdata=0xCAFEBABE -> hi_q=0x12345678 and lo_q=0xCAFEBABE one edge after each write. A further mthi while busy leaves hi_q unchanged.
- cancel asserted 10 cycles into WAIT after HI/LO preloaded with 0x1/0x2 -> mult_stop one-cycle pulse; busy drops the next cycle; no done; hi_q=0x1 and lo_q=0x2.
- rst low asynchronously in WAIT mid-multiply -> all outputs zero immediately. Later start with 2 x 2 after reset release -> lo_q=4 with full latency.
- start held high for 40 cycles -> exactly one multiply per IDLE visit: second mult_init pulse occurs the cycle after returning to IDLE, and no operand change is seen mid-operation.

Source files
------------

// File: rtl/hilo_seq.sv
// HI/LO register pair and multiply sequencer for the Booth multiplier.
// Define HILO_FWD_EN to forward mult_hi/mult_lo onto hi_q/lo_q during CAPTURE.
module hilo_seq #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic             mult_init,
  output logic             mult_stop,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE
  } state_t;

  localparam logic [5:0] LP_LOAD = 6'(MULT_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_init;
  logic             r_stop;
  logic             r_done;
  logic             w_go;
  logic             w_abort;
  logic             w_idle;

  assign w_idle = (r_state == S_IDLE);

  always_comb begin
    w_next  = r_state;
    w_go    = 1'b0;
    w_abort = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_go   = 1'b1;
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (cancel) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cancel) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cnt == 6'd0) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Pulses are registered from the next-state decode so they align with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_init  <= 1'b0;
      r_stop  <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_next;
      r_init  <= w_go;
      r_stop  <= w_abort;
      r_done  <= (w_next == S_CAPTURE);
      if (w_go) begin
        r_a <= op_a;
        r_b <= op_b;
      end
      if (r_state == S_LAUNCH && !cancel) begin
        r_cnt <= LP_LOAD;
      end else if (r_state == S_WAIT && r_cnt != 6'd0) begin
        r_cnt <= r_cnt - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_hi <= mult_hi;
      r_lo <= mult_lo;
    end else if (w_idle) begin
      if (mthi) r_hi <= wdata;
      if (mtlo) r_lo <= wdata;
    end
  end

  assign mult_a    = r_a;
  assign mult_b    = r_b;
  assign mult_init = r_init;
  assign mult_stop = r_stop;
  assign done      = r_done;
  assign busy      = !w_idle;

`ifdef HILO_FWD_EN
  assign hi_q = (r_state == S_CAPTURE) ? mult_hi : r_hi;
  assign lo_q = (r_state == S_CAPTURE) ? mult_lo : r_lo;
`else
  assign hi_q = r_hi;
  assign lo_q = r_lo;
`endif

endmodule

// File: tb/tb_hilo_seq.sv
// Self-checking bench for hilo_seq with a signed multiplier stand-in.
// Expected HI/LO and timing come from a product/cycle-count reference model.
module tb_hilo_seq;

  localparam int W   = 32;
  localparam int LAT = 34;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cancel;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] wdata;
  logic [W-1:0] mult_hi;
  logic [W-1:0] mult_lo;
  logic [W-1:0] mult_a;
  logic [W-1:0] mult_b;
  logic         mult_init;
  logic         mult_stop;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
  logic         busy;
  logic         done;

  int n_run  = 0;
  int n_fail = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  logic [63:0] w_prod;

  always #5 clk = ~clk;

  assign w_prod  = 64'(longint'(int'(mult_a)) * longint'(int'(mult_b)));
  assign mult_hi = w_prod[63:32];
  assign mult_lo = w_prod[31:0];

  hilo_seq #(.WIDTH(W), .MULT_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .cancel    (cancel),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .mult_hi   (mult_hi),
    .mult_lo   (mult_lo),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_init (mult_init),
    .mult_stop (mult_stop),
    .hi_q      (hi_q),
    .lo_q      (lo_q),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint p;
    p = longint'(int'(a)) * longint'(int'(b));
    return 64'(p);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 0; cancel = 0; mthi = 0; mtlo = 0;
    op_a = '0; op_b = '0; wdata = '0;
    #2 rst = 1'b0;
    #1;
    n_run++;
    if ({hi_q, lo_q, mult_a, mult_b, mult_init, mult_stop, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: hi=%h lo=%h a=%h b=%h init=%b stop=%b busy=%b done=%b, required all 0",
               hi_q, lo_q, mult_a, mult_b, mult_init, mult_stop, busy, done);
    end
    step();
    step();
    rst = 1'b1;
    step();
    m_hi = '0;
    m_lo = '0;
  endtask

  // Full multiply from IDLE; optional cancel with start, or cancel during CAPTURE.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit cancel_with_start, input bit cancel_in_cap,
                          input string nm);
    bit          init_ok = 1, busy_ok = 1, done_ok = 1, opnd_ok = 1, stop_ok = 1;
    logic [63:0] p;
    p = ref_prod(a, b);
    op_a = a; op_b = b; start = 1; cancel = cancel_with_start;
    step();
    start = 0; cancel = 0;
    op_a = $urandom; op_b = $urandom;
    for (int c = 1; c <= LAT + 2; c++) begin
      if (c > 1) step();
      if (mult_init !== (c == 1))       init_ok = 0;
      if (busy !== 1'b1)                busy_ok = 0;
      if (done !== (c == LAT + 2))      done_ok = 0;
      if (mult_a !== a || mult_b !== b) opnd_ok = 0;
      if (mult_stop !== 1'b0)           stop_ok = 0;
    end
    if (cancel_in_cap) cancel = 1;
    step();
    cancel = 0;
    m_hi = p[63:32];
    m_lo = p[31:0];
    n_run++;
    if (!init_ok) begin n_fail++; $display("FAIL %s init_timing: pulse not only in cycle 1", nm); end
    n_run++;
    if (!busy_ok) begin n_fail++; $display("FAIL %s busy_window: busy low inside cycles 1..%0d", nm, LAT + 2); end
    n_run++;
    if (!done_ok) begin n_fail++; $display("FAIL %s done_timing: done not only in cycle %0d", nm, LAT + 2); end
    n_run++;
    if (!opnd_ok) begin n_fail++; $display("FAIL %s operands: mult_a/b changed or wrong, required %h/%h", nm, a, b); end
    n_run++;
    if (!stop_ok) begin n_fail++; $display("FAIL %s stop: mult_stop seen during multiply", nm); end
    n_run++;
    if (busy !== 1'b0 || done !== 1'b0 || mult_stop !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end_state: busy=%b done=%b stop=%b, required 0/0/0", nm, busy, done, mult_stop);
    end
    n_run++;
    if (hi_q !== m_hi || lo_q !== m_lo) begin
      n_fail++;
      $display("FAIL %s result: hi=%h lo=%h, required hi=%h lo=%h", nm, hi_q, lo_q, m_hi, m_lo);
    end
  endtask

  task automatic test_multiply();
    run_mult(32'd6, 32'd7, 0, 0, "mul_6x7");
    run_mult(32'hFFFFFFFD, 32'd5, 0, 0, "mul_m3x5");
    for (int i = 0; i < 3; i++) run_mult($urandom, $urandom, 0, 0, "mul_rand");
  endtask

  task automatic test_mthi_mtlo();
    logic [W-1:0] a, b, w;
    logic [63:0]  p;
    wdata = 32'h12345678; mthi = 1;
    step();
    mthi = 0; m_hi = 32'h12345678;
    n_run++;
    if (hi_q !== m_hi || lo_q !== m_lo) begin
      n_fail++; $display("FAIL mthi: hi=%h lo=%h, required %h %h", hi_q, lo_q, m_hi, m_lo);
    end
    wdata = 32'hCAFEBABE; mtlo = 1;
    step();
    mtlo = 0; m_lo = 32'hCAFEBABE;
    n_run++;
    if (hi_q !== m_hi || lo_q !== m_lo) begin
      n_fail++; $display("FAIL mtlo: hi=%h lo=%h, required %h %h", hi_q, lo_q, m_hi, m_lo);
    end
    w = $urandom; wdata = w; mthi = 1; mtlo = 1;
    step();
    mthi = 0; mtlo = 0; m_hi = w; m_lo = w;
    n_run++;
    if (hi_q !== m_hi || lo_q !== m_lo) begin
      n_fail++; $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required %h", hi_q, lo_q, w);
    end
    a = $urandom; b = $urandom; p = ref_prod(a, b);
    op_a = a; op_b = b; start = 1;
    step();
    start = 0; wdata = ~w; mthi = 1; mtlo = 1;
    step();
    mthi = 0; mtlo = 0;
    n_run++;
    if (hi_q !== m_hi || lo_q !== m_lo) begin
      n_fail++; $display("FAIL mt_while_busy: hi=%h lo=%h, required %h %h", hi_q, lo_q, m_hi, m_lo);
    end
    for (int i = 0; i < LAT + 1; i++) step();
    m_hi = p[63:32]; m_lo = p[31:0];
    n_run++;
    if (hi_q !== m_hi || lo_q !== m_lo || busy !== 1'b0) begin
      n_fail++; $display("FAIL mt_busy_result: hi=%h lo=%h busy=%b, required %h %h 0", hi_q, lo_q, busy, m_hi, m_lo);
    end
    a = $urandom; b = $urandom; p = ref_prod(a, b); w = $urandom;
    op_a = a; op_b = b; start = 1; wdata = w; mthi = 1;
    step();
    start = 0; mthi = 0;
    n_run++;
    if (hi_q !== w || mult_init !== 1'b1) begin
      n_fail++; $display("FAIL start_with_mthi: hi=%h init=%b, required %h 1", hi_q, mult_init, w);
    end
    for (int i = 0; i < LAT + 2; i++) step();
    m_hi = p[63:32]; m_lo = p[31:0];
    n_run++;
    if (hi_q !== m_hi || lo_q !== m_lo) begin
      n_fail++; $display("FAIL start_with_mthi_result: hi=%h lo=%h, required %h %h", hi_q, lo_q, m_hi, m_lo);
    end
  endtask

  task automatic test_cancel();
    bit quiet = 1;
    wdata = 32'h1; mthi = 1;
    step();
    mthi = 0; wdata = 32'h2; mtlo = 1;
    step();
    mtlo = 0; m_hi = 32'h1; m_lo = 32'h2;
    op_a = $urandom; op_b = $urandom; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 10; i++) step();
    cancel = 1;
    step();
    cancel = 0;
    n_run++;
    if (mult_stop !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL cancel_wait: stop=%b busy=%b done=%b, required 1 0 0", mult_stop, busy, done);
    end
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      if (mult_stop !== 1'b0 || busy !== 1'b0 || done !== 1'b0) quiet = 0;
    end
    n_run++;
    if (!quiet) begin n_fail++; $display("FAIL cancel_quiet: activity after abort, required none"); end
    n_run++;
    if (hi_q !== m_hi || lo_q !== m_lo) begin
      n_fail++; $display("FAIL cancel_hilo: hi=%h lo=%h, required %h %h", hi_q, lo_q, m_hi, m_lo);
    end
    op_a = $urandom; op_b = $urandom; start = 1;
    step();
    start = 0; cancel = 1;
    step();
    cancel = 0;
    n_run++;
    if (mult_stop !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL cancel_launch: stop=%b busy=%b, required 1 0", mult_stop, busy);
    end
    step();
    cancel = 1;
    step();
    cancel = 0;
    n_run++;
    if (mult_stop !== 1'b0 || busy !== 1'b0 || hi_q !== m_hi || lo_q !== m_lo) begin
      n_fail++; $display("FAIL cancel_idle: stop=%b busy=%b hi=%h lo=%h, required 0 0 %h %h",
                         mult_stop, busy, hi_q, lo_q, m_hi, m_lo);
    end
    run_mult($urandom, $urandom, 1, 0, "cancel_with_start");
    run_mult($urandom, $urandom, 0, 1, "cancel_in_capture");
  endtask

  task automatic test_async_reset();
    op_a = $urandom; op_b = $urandom; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 14; i++) step();
    #2 rst = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    n_run++;
    if ({hi_q, lo_q, mult_a, mult_b, mult_init, mult_stop, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: hi=%h lo=%h a=%h b=%h init=%b stop=%b busy=%b done=%b, required all 0",
               hi_q, lo_q, mult_a, mult_b, mult_init, mult_stop, busy, done);
    end
    step();
    rst = 1'b1;
    step();
    n_run++;
    if (mult_stop !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_stop: stop=%b busy=%b, required 0 0", mult_stop, busy);
    end
    run_mult(32'd2, 32'd2, 0, 0, "post_reset_2x2");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] prev_a, prev_b, exp_a, exp_b;
    logic [63:0]  p;
    bit           init_ok = 1, opnd_ok = 1;
    exp_a = '0; exp_b = '0;
    op_a = $urandom; op_b = $urandom; start = 1;
    for (int c = 1; c <= 2 * (LAT + 3); c++) begin
      prev_a = op_a; prev_b = op_b;
      step();
      if ((c - 1) % (LAT + 3) == 0) begin
        exp_a = prev_a; exp_b = prev_b;
      end
      if (mult_init !== ((c - 1) % (LAT + 3) == 0)) init_ok = 0;
      if (mult_a !== exp_a || mult_b !== exp_b) opnd_ok = 0;
      op_a = $urandom; op_b = $urandom;
    end
    start = 0;
    p = ref_prod(exp_a, exp_b);
    m_hi = p[63:32]; m_lo = p[31:0];
    n_run++;
    if (!init_ok) begin n_fail++; $display("FAIL held_start_init: pulses not at cycles 1 and %0d", LAT + 4); end
    n_run++;
    if (!opnd_ok) begin n_fail++; $display("FAIL held_start_operands: operands changed mid-operation"); end
    n_run++;
    if (hi_q !== m_hi || lo_q !== m_lo || busy !== 1'b0) begin
      n_fail++; $display("FAIL held_start_result: hi=%h lo=%h busy=%b, required %h %h 0", hi_q, lo_q, busy, m_hi, m_lo);
    end
    step();
    n_run++;
    if (mult_init !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL held_start_release: init=%b busy=%b, required 0 0", mult_init, busy);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_mthi_mtlo();
    test_cancel();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
